// File: rtl/compare_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states, compare outcomes
// and the mapping from an outcome to the {gt,eq,lt} one-hot result.
package compare_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    CMP_LT,
    CMP_EQ,
    CMP_GT
  } cmp_result_t;

  function automatic logic [2:0] result_onehot(input cmp_result_t r);
    case (r)
      CMP_GT:  return 3'b100;
      CMP_EQ:  return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/bit_compare_cell.sv
// Single-bit compare cell: flags a difference and which operand wins at this position,
// inverting the sense on the sign bit of a two's-complement compare.
module bit_compare_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic is_sign_bit,
  input  logic signed_mode,
  output logic differ,
  output logic a_greater
);

  always_comb begin
    differ = a_bit ^ b_bit;
    // A set sign bit means a negative value, so a 1 in A loses to a 0 in B.
    if (signed_mode && is_sign_bit) a_greater = b_bit & ~a_bit;
    else                            a_greater = a_bit & ~b_bit;
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator with valid/ready handshakes on both sides,
// one bit examined per clock, optional early exit on the first differing bit.
module serial_magnitude_comparator
  import compare_pkg::*;
#(
  parameter  int NUM_BITS   = 4,
  parameter  bit EARLY_EXIT = 1'b1,
  localparam int IDX_W      = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1,
  localparam int CNT_W      = $clog2(NUM_BITS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                signed_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                gt,
  output logic                eq,
  output logic                lt,
  output logic [CNT_W-1:0]    bits_seen
);

  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NUM_BITS - 1);

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] a_q, b_q;
  logic                signed_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    bits_seen_q;
  logic                decided_q;
  logic [2:0]          res_q;

  logic accept, last_bit, is_sign_bit, differ, a_greater;

  assign accept      = in_valid && in_ready;
  assign last_bit    = (idx_q == '0);
  assign is_sign_bit = (idx_q == IDX_MSB);

  bit_compare_cell u_cell (
    .a_bit       (a_q[idx_q]),
    .b_bit       (b_q[idx_q]),
    .is_sign_bit (is_sign_bit),
    .signed_mode (signed_q),
    .differ      (differ),
    .a_greater   (a_greater)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)                           state_d = ST_SCAN;
      ST_SCAN: if ((EARLY_EXIT && differ) || last_bit) state_d = ST_DONE;
      ST_DONE: if (out_ready)                          state_d = ST_IDLE;
      default:                                         state_d = ST_IDLE;
    endcase
  end

  // Scan datapath: decided_q latches the first difference so later bits cannot override it
  // when the scan runs the full width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      idx_q       <= '0;
      bits_seen_q <= '0;
      decided_q   <= 1'b0;
      res_q       <= '0;
    end else if (accept) begin
      a_q         <= a;
      b_q         <= b;
      signed_q    <= signed_mode;
      idx_q       <= IDX_MSB;
      bits_seen_q <= '0;
      decided_q   <= 1'b0;
      res_q       <= '0;
    end else if (state_q == ST_SCAN) begin
      bits_seen_q <= bits_seen_q + CNT_W'(1);
      if (!last_bit) idx_q <= idx_q - IDX_W'(1);
      if (differ && !decided_q) begin
        res_q     <= result_onehot(a_greater ? CMP_GT : CMP_LT);
        decided_q <= 1'b1;
      end else if (last_bit && !decided_q) begin
        res_q     <= result_onehot(CMP_EQ);
      end
    end
  end

  assign in_ready       = (state_q == ST_IDLE);
  assign out_valid      = (state_q == ST_DONE);
  assign {gt, eq, lt}   = res_q;
  assign bits_seen      = bits_seen_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator: one early-exit and one full-scan instance
// share the operand side; results, bits_seen and latency are checked against hand values.
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, sm;
  logic [3:0] a, b;

  logic       ir1, ov1, gt1, eq1, lt1;
  logic [2:0] bits1;
  logic       ir0, ov0, gt0, eq0, lt0;
  logic [2:0] bits0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.NUM_BITS(4), .EARLY_EXIT(1'b1)) dut_ee1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
    .signed_mode(sm), .out_valid(ov1), .out_ready(out_ready),
    .gt(gt1), .eq(eq1), .lt(lt1), .bits_seen(bits1)
  );

  serial_magnitude_comparator #(.NUM_BITS(4), .EARLY_EXIT(1'b0)) dut_ee0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b),
    .signed_mode(sm), .out_valid(ov0), .out_ready(out_ready),
    .gt(gt0), .eq(eq0), .lt(lt0), .bits_seen(bits0)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sm;
    logic [2:0] exp_res;  // {gt,eq,lt}
    int         exp_k;    // early-exit latency == bits examined
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    @(negedge clk);
    while (!(ir1 && ir0) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check({name, "_idle_timeout"}, 0, 1);
  endtask

  task automatic run_op(input string name, input logic [3:0] av, input logic [3:0] bv,
                        input logic smv,
                        output logic [2:0] r1, output int b1, output int k1,
                        output logic [2:0] r0, output int b0, output int k0);
    wait_idle(name);
    a = av; b = bv; sm = smv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    k1 = -1; k0 = -1; r1 = '0; r0 = '0; b1 = -1; b0 = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k1 < 0 && ov1) begin k1 = k; r1 = {gt1, eq1, lt1}; b1 = int'(bits1); end
      if (k0 < 0 && ov0) begin k0 = k; r0 = {gt0, eq0, lt0}; b0 = int'(bits0); end
      if (k1 >= 0 && k0 >= 0) break;
    end
  endtask

  task automatic check_op(input string name, input logic [3:0] av, input logic [3:0] bv,
                          input logic smv, input logic [2:0] exp_res, input int exp_k);
    logic [2:0] r1, r0;
    int b1, k1, b0, k0;
    run_op(name, av, bv, smv, r1, b1, k1, r0, b0, k0);
    check({name, "_res_ee1"},  int'(r1), int'(exp_res));
    check({name, "_bits_ee1"}, b1, exp_k);
    check({name, "_lat_ee1"},  k1, exp_k);
    check({name, "_res_ee0"},  int'(r0), int'(exp_res));
    check({name, "_bits_ee0"}, b0, 4);
    check({name, "_lat_ee0"},  k0, 4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'h8, 4'h7, 1'b0, 3'b100, 1};  // unsigned, differ at MSB
    vecs[1]  = '{4'h5, 4'h5, 1'b0, 3'b010, 4};
    vecs[2]  = '{4'h4, 4'h5, 1'b0, 3'b001, 4};
    vecs[3]  = '{4'hF, 4'h1, 1'b1, 3'b001, 1};  // -1 < 1
    vecs[4]  = '{4'hF, 4'h1, 1'b0, 3'b100, 1};  // 15 > 1
    vecs[5]  = '{4'h8, 4'h7, 1'b1, 3'b001, 1};  // -8 < 7
    vecs[6]  = '{4'h6, 4'h2, 1'b1, 3'b100, 2};
    vecs[7]  = '{4'h9, 4'hA, 1'b1, 3'b001, 3};  // -7 < -6
    vecs[8]  = '{4'h0, 4'h0, 1'b1, 3'b010, 4};
    vecs[9]  = '{4'hF, 4'hF, 1'b1, 3'b010, 4};
    vecs[10] = '{4'h3, 4'h1, 1'b0, 3'b100, 3};

    // Reset state, with in_valid held high to show it is ignored.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; a = 4'h3; b = 4'h1; sm = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ee1", int'({ir1, ov1, gt1, eq1, lt1, bits1}), int'(8'b1000_0000));
    check("reset_ee0", int'({ir0, ov0, gt0, eq0, lt0, bits0}), int'(8'b1000_0000));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm,
               vecs[i].exp_res, vecs[i].exp_k);

    // Backpressure: result held, no accept while the consumer stalls.
    wait_idle("bp");
    a = 4'h8; b = 4'h7; sm = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 a = 4'h0; b = 4'h9;
    @(posedge clk);
    #1 check("bp_lat1_ee1", int'(ov1), 1);
    repeat (3) @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d", c),
            int'({ov1, ov0, ir1, ir0, gt1, eq1, lt1, gt0, eq0, lt0, bits1, bits0}),
            int'({4'b1100, 3'b100, 3'b100, 3'd1, 3'd4}));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release",
          int'({ov1, ov0, ir1, ir0, gt1, eq1, lt1, gt0, eq0, lt0, bits1, bits0}),
          int'({4'b0011, 3'b100, 3'b100, 3'd1, 3'd4}));

    // Asynchronous reset in the second scan cycle of a=1, b=0.
    wait_idle("rst");
    a = 4'h1; b = 4'h0; sm = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_ee1", int'({ir1, ov1, gt1, eq1, lt1, bits1}), int'(8'b1000_0000));
    check("midreset_ee0", int'({ir0, ov0, gt0, eq0, lt0, bits0}), int'(8'b1000_0000));
    @(negedge clk);
    rst_n = 1'b1;
    check_op("after_reset", 4'h2, 4'h3, 1'b0, 3'b001, 4);

    // Exhaustive sweep against an integer-compare reference.
    for (int s = 0; s < 2; s++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          logic [3:0] av, bv, x;
          logic [2:0] exp_res, r1, r0;
          int va, vb, exp_k, b1, k1, b0, k0;
          av = 4'(ai); bv = 4'(bi); x = av ^ bv;
          va = (s == 1) ? int'($signed(av)) : ai;
          vb = (s == 1) ? int'($signed(bv)) : bi;
          exp_res = (va > vb) ? 3'b100 : (va == vb) ? 3'b010 : 3'b001;
          exp_k = 4;
          for (int p = 3; p >= 0; p--)
            if (x[p]) begin exp_k = 4 - p; break; end
          run_op("sweep", av, bv, s[0], r1, b1, k1, r0, b0, k0);
          check($sformatf("sweep_s%0d_a%0d_b%0d_onehot", s, ai, bi),
                int'({$onehot(r1), $onehot(r0)}), 3);
          check($sformatf("sweep_s%0d_a%0d_b%0d_res", s, ai, bi),
                int'({r1, r0}), int'({exp_res, exp_res}));
          check($sformatf("sweep_s%0d_a%0d_b%0d_lat_bits", s, ai, bi),
                (k1 << 12) | (b1 << 8) | (k0 << 4) | b0,
                (exp_k << 12) | (exp_k << 8) | (4 << 4) | 4);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
